srambank_param_ctl: RTL and testbench

Parametrised successor of the fixed 256x4x18 synchronous SRAM bank.
- Generalises depth, word width and bank count.
- Adds per-lane write masking, an optional output pipeline stage, a read-valid strobe and a sticky collision flag.
- Adds a post-reset clear engine that zeroes every word before first access.
- Sits as the leaf memory macro model behind the SRAM bank controllers.

---
 rtl/srambank_param_ctl_pkg.sv | 17 +
 rtl/srambank_param_ctl_if.sv | 34 +++
 rtl/srambank_param_ctl_array.sv | 43 ++++
 rtl/srambank_param_ctl.sv | 116 +++++++++++
 tb/tb_srambank_param_ctl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/srambank_param_ctl_pkg.sv
// Shared types and sizing helpers for the parametrised SRAM bank macro model.
//   state_t : clear-engine FSM states
//   lanes() : number of write-mask lanes in a word
//   aw()    : address width for a given depth
package srambank_pkg;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   function automatic int lanes(input int width, input int lane_w);
      return width / lane_w;
   endfunction

   function automatic int aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/srambank_param_ctl_if.sv
// Access bus of the SRAM bank macro.
//   master : address, wd, wmask, banksel, read, write, clr_collision out;
//            dataout, rvalid, ready, collision in
//   slave  : mirror of master
interface srambank_param_ctl_if #(
   parameter int WIDTH  = 18,
   parameter int DEPTH  = 1024,
   parameter int LANE_W = 9
);
   localparam int AW = srambank_pkg::aw(DEPTH);
   localparam int NL = srambank_pkg::lanes(WIDTH, LANE_W);

   logic [AW-1:0]    address;
   logic [WIDTH-1:0] wd;
   logic [NL-1:0]    wmask;
   logic             banksel;
   logic             read;
   logic             write;
   logic             clr_collision;
   logic [WIDTH-1:0] dataout;
   logic             rvalid;
   logic             ready;
   logic             collision;

   modport master (
      output address, wd, wmask, banksel, read, write, clr_collision,
      input  dataout, rvalid, ready, collision
   );

   modport slave (
      input  address, wd, wmask, banksel, read, write, clr_collision,
      output dataout, rvalid, ready, collision
   );
endinterface

// File: rtl/srambank_param_ctl_array.sv
// Masked-write, registered-read storage array.
//   clk, rst_n : clock, async active-low reset (read register only)
//   address    : word address
//   wd, wmask  : write data, per-lane write enables
//   we, re     : write / read strobes (never both from the controller)
//   q          : registered read data, holds between reads
module srambank_array
   import srambank_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int DEPTH  = 1024,
   parameter int LANE_W = 9,
   localparam int AW    = aw(DEPTH),
   localparam int NL    = lanes(WIDTH, LANE_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] wd,
   input  logic [NL-1:0]    wmask,
   input  logic             we,
   input  logic             re,
   output logic [WIDTH-1:0] q
);

   // One storage column per lane so each mask bit owns its own write port.
   for (genvar i = 0; i < NL; i++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] q_l;

      always_ff @(posedge clk) begin
         if (we && wmask[i]) mem[address] <= wd[i*LANE_W +: LANE_W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)  q_l <= '0;
         else if (re) q_l <= mem[address];
      end

      assign q[i*LANE_W +: LANE_W] = q_l;
   end

endmodule

// File: rtl/srambank_param_ctl.sv
// Parametrised SRAM bank macro model: zero-fill engine after reset, masked
// writes, 1- or 2-cycle reads with rvalid strobe, sticky collision flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of srambank_param_ctl_if (see interface file)
module srambank_param_ctl
   import srambank_pkg::*;
#(
   parameter int WIDTH          = 18,
   parameter int DEPTH          = 1024,
   parameter int LANE_W         = 9,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   srambank_param_ctl_if.slave   bus
);

   localparam int AW     = aw(DEPTH);
   localparam int NL     = lanes(WIDTH, LANE_W);
   localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

   state_t           state, state_nxt;
   logic [AW-1:0]    clr_addr;
   logic             ready_q;
   logic             clearing;
   logic             acc, wr, rd;
   logic [AW-1:0]    arr_addr;
   logic [WIDTH-1:0] arr_wd;
   logic [NL-1:0]    arr_wmask;
   logic [WIDTH-1:0] q;
   logic [STAGES:0]  vld_pipe;
   logic [STAGES:1]  vld_q;
   logic             coll_q;

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_addr == AW'(DEPTH - 1)) state_nxt = READY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               clr_addr <= '0;
      else if (state == CLEAR)  clr_addr <= clr_addr + 1'b1;
   end

   // ready is registered so that it stays low through reset and rises on the
   // edge that leaves CLEAR (or the first edge when no clear is configured).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= (state_nxt == READY);
   end

   assign clearing  = (state == CLEAR);
   assign acc       = ready_q & bus.banksel;
   assign wr        = acc & bus.write;
   assign rd        = acc & bus.read & ~bus.write;   // write wins a collision

   // ---------------- array with clear port muxed in ----------------
   assign arr_addr  = clearing ? clr_addr : bus.address;
   assign arr_wd    = clearing ? '0       : bus.wd;
   assign arr_wmask = clearing ? '1       : bus.wmask;

   srambank_array #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .LANE_W (LANE_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (arr_addr),
      .wd      (arr_wd),
      .wmask   (arr_wmask),
      .we      (clearing | wr),
      .re      (rd),
      .q       (q)
   );

   // ---------------- read valid pipeline ----------------
   assign vld_pipe = {vld_q, rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_pipe[STAGES-1:0];
   end

   assign bus.rvalid = vld_pipe[STAGES];

   if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)           dout_q <= '0;
         else if (vld_pipe[1]) dout_q <= q;
      end
      assign bus.dataout = dout_q;
   end else begin : g_noreg
      assign bus.dataout = q;
   end

   // ---------------- collision flag ----------------
   // Evaluated even while clearing; a new collision beats a clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    coll_q <= 1'b0;
      else if (bus.banksel & bus.read & bus.write)   coll_q <= 1'b1;
      else if (bus.clr_collision)                    coll_q <= 1'b0;
   end

   assign bus.collision = coll_q;
   assign bus.ready     = ready_q;

endmodule

// File: tb/tb_srambank_param_ctl.sv
module tb_srambank_param_ctl;

   localparam int WIDTH = 18;
   localparam int DEPTH = 16;
   localparam int LW    = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  address = '0;
   logic [17:0] wd = '0;
   logic [1:0]  wmask = '0;
   logic        banksel = 1'b0, read = 1'b0, write = 1'b0, clr_collision = 1'b0;

   srambank_param_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW)) if0 ();
   srambank_param_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW)) if1 ();
   srambank_param_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW)) if2 ();

   assign if0.address = address;  assign if1.address = address;  assign if2.address = address;
   assign if0.wd = wd;            assign if1.wd = wd;            assign if2.wd = wd;
   assign if0.wmask = wmask;      assign if1.wmask = wmask;      assign if2.wmask = wmask;
   assign if0.banksel = banksel;  assign if1.banksel = banksel;  assign if2.banksel = banksel;
   assign if0.read = read;        assign if1.read = read;        assign if2.read = read;
   assign if0.write = write;      assign if1.write = write;      assign if2.write = write;
   assign if0.clr_collision = clr_collision;
   assign if1.clr_collision = clr_collision;
   assign if2.clr_collision = clr_collision;

   // dut0: 1-cycle read, dut1: 2-cycle read, dut2: no clear engine
   srambank_param_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW), .OUT_REG(0), .CLEAR_ON_RESET(1))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   srambank_param_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW), .OUT_REG(1), .CLEAR_ON_RESET(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   srambank_param_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LW), .OUT_REG(0), .CLEAR_ON_RESET(0))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // inputs change on negedge; outputs sampled on the following negedge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      banksel = 1'b0; read = 1'b0; write = 1'b0; wmask = '0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [17:0] d, input logic [1:0] m);
      banksel = 1'b1; write = 1'b1; read = 1'b0; address = a; wd = d; wmask = m;
      cyc();
      idle();
   endtask

   // single read: dut0 shows data after one edge, dut1 after two
   task automatic do_read(input string tag, input logic [3:0] a, input logic [17:0] exp);
      banksel = 1'b1; read = 1'b1; write = 1'b0; address = a;
      cyc();
      idle();
      chk({tag, "_rv0"}, 32'(if0.rvalid), 32'd1);
      chk({tag, "_d0"},  32'(if0.dataout), 32'(exp));
      chk({tag, "_rv1_early"}, 32'(if1.rvalid), 32'd0);
      cyc();
      chk({tag, "_rv1"}, 32'(if1.rvalid), 32'd1);
      chk({tag, "_d1"},  32'(if1.dataout), 32'(exp));
      chk({tag, "_rv0_off"}, 32'(if0.rvalid), 32'd0);
   endtask

   task automatic wait_clear(input string tag);
      for (int k = 1; k <= DEPTH; k++) begin
         cyc();
         chk($sformatf("%s_rdy0_%0d", tag, k), 32'(if0.ready), 32'(k == DEPTH));
         chk($sformatf("%s_rdy1_%0d", tag, k), 32'(if1.ready), 32'(k == DEPTH));
         if (k == 1) chk({tag, "_rdy2"}, 32'(if2.ready), 32'd1);
      end
   endtask

   initial begin
      idle();
      repeat (3) @(negedge clk);
      chk("rst_d0",   32'(if0.dataout),   32'd0);
      chk("rst_rv0",  32'(if0.rvalid),    32'd0);
      chk("rst_rdy0", 32'(if0.ready),     32'd0);
      chk("rst_rdy2", 32'(if2.ready),     32'd0);
      chk("rst_col0", 32'(if0.collision), 32'd0);

      // clear runs for DEPTH cycles, ready on the following cycle
      rst_n = 1'b1;
      wait_clear("clr");

      // read every address back-to-back: all zero, one rvalid per read
      for (int a = 0; a < DEPTH; a++) begin
         banksel = 1'b1; read = 1'b1; address = 4'(a);
         cyc();
         chk($sformatf("all_rv0_%0d", a), 32'(if0.rvalid), 32'd1);
         chk($sformatf("all_d0_%0d", a),  32'(if0.dataout), 32'd0);
         chk($sformatf("all_rv1_%0d", a), 32'(if1.rvalid), 32'(a != 0));
      end
      idle();
      cyc();
      chk("all_rv1_last", 32'(if1.rvalid), 32'd1);
      chk("all_d1_last",  32'(if1.dataout), 32'd0);

      // lower-lane-only write
      do_write(4'd5, 18'h3FFFF, 2'b01);
      do_read("mask", 4'd5, 18'h001FF);

      // read+write collision: write wins, no read, flag set
      banksel = 1'b1; read = 1'b1; write = 1'b1; address = 4'd7; wd = 18'h12345; wmask = 2'b11;
      cyc();
      idle();
      chk("col_flag0", 32'(if0.collision), 32'd1);
      chk("col_rv0",   32'(if0.rvalid),    32'd0);
      chk("col_d0",    32'(if0.dataout),   32'h001FF);
      cyc();
      chk("col_rv1",   32'(if1.rvalid),    32'd0);
      chk("col_flag1", 32'(if1.collision), 32'd1);
      // set beats clear
      banksel = 1'b1; read = 1'b1; write = 1'b1; wmask = 2'b11; clr_collision = 1'b1;
      cyc();
      idle();
      chk("col_setpri", 32'(if0.collision), 32'd1);
      cyc();
      clr_collision = 1'b0;
      chk("col_clr",    32'(if0.collision), 32'd0);
      do_read("colmem", 4'd7, 18'h12345);

      // banksel=0 write and read are ignored
      banksel = 1'b0; write = 1'b1; address = 4'd3; wd = 18'h2AAAA; wmask = 2'b11;
      cyc();
      idle();
      read = 1'b1; address = 4'd3;
      cyc();
      idle();
      chk("nbs_rv0", 32'(if0.rvalid),  32'd0);
      chk("nbs_d0",  32'(if0.dataout), 32'h12345);
      cyc();
      chk("nbs_rv1", 32'(if1.rvalid),  32'd0);
      chk("nbs_d1",  32'(if1.dataout), 32'h12345);
      do_read("nbsmem", 4'd3, 18'h0);

      // consecutive reads after writes
      do_write(4'd1, 18'h11, 2'b11);
      do_write(4'd2, 18'h22, 2'b11);
      do_write(4'd3, 18'h33, 2'b11);
      for (int a = 1; a <= 4; a++) begin
         if (a <= 3) begin banksel = 1'b1; read = 1'b1; address = 4'(a); end
         else idle();
         cyc();
         chk($sformatf("seq_rv0_%0d", a), 32'(if0.rvalid), 32'(a <= 3));
         chk($sformatf("seq_d0_%0d", a), 32'(if0.dataout), 32'h11 * 32'((a <= 3) ? a : 3));
         chk($sformatf("seq_rv1_%0d", a), 32'(if1.rvalid), 32'(a >= 2));
         if (a >= 2) chk($sformatf("seq_d1_%0d", a), 32'(if1.dataout), 32'h11 * 32'(a - 1));
      end
      idle();

      // collision then async reset while running
      banksel = 1'b1; read = 1'b1; write = 1'b1; address = 4'd9; wd = '0; wmask = 2'b11;
      cyc();
      idle();
      rst_n = 1'b0;
      #1;
      chk("arst_d0",   32'(if0.dataout),   32'd0);
      chk("arst_d1",   32'(if1.dataout),   32'd0);
      chk("arst_rdy0", 32'(if0.ready),     32'd0);
      chk("arst_col0", 32'(if0.collision), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // abort the clear at clr_addr=9 and restart
      repeat (9) cyc();
      rst_n = 1'b0;
      #1;
      chk("mid_rdy0", 32'(if0.ready),  32'd0);
      chk("mid_rv0",  32'(if0.rvalid), 32'd0);
      #1;
      rst_n = 1'b1;
      wait_clear("reclr");
      do_read("post1", 4'd1, 18'h0);
      do_read("post5", 4'd5, 18'h0);
      do_read("post7", 4'd7, 18'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
